// File: rtl/tqvp_crc32_pkg.sv
// Shared definitions for the TinyQV CRC-32 peripherals: polynomial constants,
// register map, STATUS layout and FSM encoding.
package tqvp_crc32_pkg;

   localparam logic [31:0] POLY    = 32'hEDB88320;
   localparam logic [31:0] INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   localparam int unsigned LEN_W = 16;
   // Shortest frame that can hold at least one payload byte plus the 4-byte CRC.
   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(5);

   // Write map
   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_LEN_LO = 4'h1;
   localparam logic [3:0] ADDR_LEN_HI = 4'h2;
   localparam logic [3:0] ADDR_DATA   = 4'h3;

   // Read map
   localparam logic [3:0] ADDR_STATUS   = 4'h4;
   localparam logic [3:0] ADDR_CRC0     = 4'h5;
   localparam logic [3:0] ADDR_CRC1     = 4'h6;
   localparam logic [3:0] ADDR_CRC2     = 4'h7;
   localparam logic [3:0] ADDR_CRC3     = 4'h8;
   localparam logic [3:0] ADDR_CNT_LO   = 4'h9;
   localparam logic [3:0] ADDR_CNT_HI   = 4'hA;
   localparam logic [3:0] ADDR_LENRD_LO = 4'hB;
   localparam logic [3:0] ADDR_LENRD_HI = 4'hC;

   // STATUS bit positions
   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_DONE    = 1;
   localparam int unsigned STAT_PASS    = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_LEN_ERR = 4;
   localparam int unsigned STAT_HOLD    = 5;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StCheck,
      StDone
   } state_e;

   function automatic logic [7:0] crc_byte(input logic [31:0] crc, input logic [1:0] idx);
      return crc[8*idx +: 8];
   endfunction

endpackage

// File: rtl/tqvp_crc32_bitstep.sv
// One bit of a reflected CRC-32 update: shifts one data bit into the register.
module tqvp_crc32_bitstep
   import tqvp_crc32_pkg::*;
(
   input  logic [31:0] crc,
   input  logic        data_bit,
   output logic [31:0] crc_next
);

   logic fb;

   always_comb begin
      fb       = crc[0] ^ data_bit;
      crc_next = (crc >> 1) ^ (fb ? POLY : 32'h0);
   end

endmodule

// File: rtl/tqvp_crc32_check.sv
// CRC-32 frame checker peripheral: bytes written to DATA are folded bit-serially
// into the CRC register; after LEN bytes the register is compared to the residue.
module tqvp_crc32_check
   import tqvp_crc32_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   state_e             state_q, state_d;
   logic [31:0]        crc_q, crc_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [LEN_W-1:0]   byte_cnt_inc;
   logic [7:0]         hold_q, hold_d;
   logic               hold_valid_q, hold_valid_d;
   logic [7:0]         shreg_q, shreg_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic               overflow_q, overflow_d;
   logic               len_err_q, len_err_d;

   logic [31:0]        crc_step;
   logic               busy;
   logic               len_wr_ok;
   logic               hold_full;
   logic [7:0]         status;
   logic               unused_ui;

   assign unused_ui = ^ui_in;

   tqvp_crc32_bitstep u_bitstep (
      .crc      (crc_q),
      .data_bit (shreg_q[0]),
      .crc_next (crc_step)
   );

   assign busy         = (state_q == StShift) || (state_q == StCheck) || hold_valid_q;
   assign len_wr_ok    = (state_q == StIdle) && (byte_cnt_q == '0) && !hold_valid_q;
   // In IDLE a pending hold byte is drained this cycle, so the slot can be refilled.
   assign hold_full    = hold_valid_q && (state_q != StIdle);
   assign byte_cnt_inc = byte_cnt_q + LEN_W'(1);

   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      len_d        = len_q;
      byte_cnt_d   = byte_cnt_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      done_d       = done_q;
      pass_d       = pass_q;
      overflow_d   = overflow_q;
      len_err_d    = len_err_q;

      unique case (state_q)
         StIdle: begin
            if (hold_valid_q) begin
               shreg_d      = hold_q;
               hold_valid_d = 1'b0;
               bit_cnt_d    = 3'd0;
               state_d      = StShift;
            end
         end
         StShift: begin
            crc_d     = crc_step;
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               byte_cnt_d = byte_cnt_inc;
               state_d    = (byte_cnt_inc == len_q) ? StCheck : StIdle;
            end
         end
         StCheck: begin
            pass_d  = (crc_q == RESIDUE);
            done_d  = 1'b1;
            state_d = StDone;
         end
         StDone: begin
         end
      endcase

      // Bus writes override the FSM; a clear aborts any frame in progress.
      if (data_write) begin
         case (address)
            ADDR_CTRL: begin
               if (data_in[0]) begin
                  state_d      = StIdle;
                  crc_d        = INIT;
                  byte_cnt_d   = '0;
                  hold_valid_d = 1'b0;
                  bit_cnt_d    = 3'd0;
                  done_d       = 1'b0;
                  pass_d       = 1'b0;
                  overflow_d   = 1'b0;
                  len_err_d    = 1'b0;
               end
            end
            ADDR_LEN_LO: if (len_wr_ok) len_d[7:0]  = data_in;
            ADDR_LEN_HI: if (len_wr_ok) len_d[15:8] = data_in;
            ADDR_DATA: begin
               if ((state_q == StDone) || hold_full) begin
                  overflow_d = 1'b1;
               end else if ((state_q == StIdle) && (byte_cnt_q == '0) && (len_q < MIN_LEN)) begin
                  len_err_d = 1'b1;
                  done_d    = 1'b1;
                  pass_d    = 1'b0;
                  state_d   = StDone;
               end else begin
                  hold_d       = data_in;
                  hold_valid_d = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         crc_q        <= INIT;
         len_q        <= '0;
         byte_cnt_q   <= '0;
         hold_q       <= 8'h00;
         hold_valid_q <= 1'b0;
         shreg_q      <= 8'h00;
         bit_cnt_q    <= 3'd0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         overflow_q   <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         crc_q        <= crc_d;
         len_q        <= len_d;
         byte_cnt_q   <= byte_cnt_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         overflow_q   <= overflow_d;
         len_err_q    <= len_err_d;
      end
   end

   always_comb begin
      status               = 8'h00;
      status[STAT_BUSY]    = busy;
      status[STAT_DONE]    = done_q;
      status[STAT_PASS]    = pass_q;
      status[STAT_OVF]     = overflow_q;
      status[STAT_LEN_ERR] = len_err_q;
      status[STAT_HOLD]    = hold_valid_q;
   end

   assign uo_out = {4'b0000, overflow_q | len_err_q, pass_q, done_q, busy};

   always_comb begin
      data_out = 8'h00;
      case (address)
         ADDR_STATUS:   data_out = status;
         ADDR_CRC0:     data_out = crc_byte(crc_q, 2'd0);
         ADDR_CRC1:     data_out = crc_byte(crc_q, 2'd1);
         ADDR_CRC2:     data_out = crc_byte(crc_q, 2'd2);
         ADDR_CRC3:     data_out = crc_byte(crc_q, 2'd3);
         ADDR_CNT_LO:   data_out = byte_cnt_q[7:0];
         ADDR_CNT_HI:   data_out = byte_cnt_q[15:8];
         ADDR_LENRD_LO: data_out = len_q[7:0];
         ADDR_LENRD_HI: data_out = len_q[15:8];
         default:       data_out = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_tqvp_crc32_check.sv
// Bench for tqvp_crc32_check: directed and random frames, outcomes checked by a
// scoreboard against a byte-wise CRC-32 model.
module tb_tqvp_crc32_check;

   localparam logic [3:0] A_CTRL = 4'h0, A_LEN_LO = 4'h1, A_LEN_HI = 4'h2, A_DATA = 4'h3;
   localparam logic [3:0] A_STATUS = 4'h4, A_CRC0 = 4'h5, A_CNT_LO = 4'h9, A_CNT_HI = 4'hA;
   localparam logic [3:0] A_LENRD_LO = 4'hB, A_LENRD_HI = 4'hC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out;
   logic [3:0] address = 4'h0;
   logic       data_write = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] frame[$];
   logic       prev_done = 1'b0;

   always #5 clk = ~clk;

   tqvp_crc32_check dut (
      .clk        (clk),
      .rst        (rst),
      .ui_in      (ui_in),
      .uo_out     (uo_out),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Scoreboard monitor: each rising done is one frame outcome.
   always @(posedge clk) begin
      #1;
      if (uo_out[1] && !prev_done) begin
         if (exp_q.size() == 0) chk("sb_unexpected_done", {24'h0, uo_out}, 32'h0);
         else chk("sb_uo_out", {24'h0, uo_out}, {24'h0, exp_q.pop_front()});
      end
      prev_done = uo_out[1];
   end

   // Classic byte-at-a-time CRC-32 with final inversion.
   function automatic logic [31:0] crc32_of(input int n);
      logic [31:0] c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, frame[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address    = a;
      data_in    = d;
      data_write = 1'b1;
      @(posedge clk);
      #1;
      data_write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      address = a;
      #1;
      d = data_out;
   endtask

   task automatic rd_crc(output logic [31:0] v);
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         rd(A_CRC0 + 4'(i), b);
         v[8*i +: 8] = b;
      end
   endtask

   task automatic rd_cnt(output logic [15:0] v);
      logic [7:0] lo, hi;
      rd(A_CNT_LO, lo);
      rd(A_CNT_HI, hi);
      v = {hi, lo};
   endtask

   task automatic set_len(input logic [15:0] n);
      wr(A_LEN_LO, n[7:0]);
      wr(A_LEN_HI, n[15:8]);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!uo_out[1] && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("done_within_budget", {31'h0, uo_out[1]}, 32'h1);
   endtask

   task automatic append_crc(input int plen);
      logic [31:0] c;
      c = crc32_of(plen);
      for (int i = 0; i < 4; i++) frame.push_back(c[8*i +: 8]);
   endtask

   // Sends the frame with safe spacing; checks the raw CRC after byte check_at.
   task automatic run_frame(input int check_at);
      int          n;
      logic        good;
      logic [31:0] trailer, raw;
      logic [15:0] cnt;
      logic [7:0]  st;
      n       = frame.size();
      trailer = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
      good    = (trailer == crc32_of(n - 4));
      exp_q.push_back({4'h0, 1'b0, good, 1'b1, 1'b0});
      for (int i = 0; i < n; i++) begin
         wr(A_DATA, frame[i]);
         idle($urandom_range(13, 9));
         if (i == check_at) begin
            rd_crc(raw);
            chk("prefix_raw_crc", raw, ~crc32_of(i + 1));
            rd_cnt(cnt);
            chk("prefix_byte_cnt", {16'h0, cnt}, i + 1);
         end
      end
      wait_done(20);
      rd_cnt(cnt);
      chk("frame_byte_cnt", {16'h0, cnt}, n);
      rd(A_STATUS, st);
      chk("frame_status", {24'h0, st}, good ? 32'h06 : 32'h02);
      if (good) begin
         rd_crc(raw);
         chk("frame_residue", raw, 32'hDEBB20E3);
      end
   endtask

   task automatic load_good_frame();
      frame.delete();
      for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
      append_crc(9);
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] raw;
      logic [15:0] cnt;
      int          plen;
      int          idx;

      idle(3);
      rst = 1'b0;
      idle(1);

      // Reset state
      chk("reset_uo_out", {24'h0, uo_out}, 32'h0);
      rd(A_STATUS, b);
      chk("reset_status", {24'h0, b}, 32'h0);
      rd_crc(raw);
      chk("reset_crc", raw, 32'hFFFFFFFF);
      rd(A_LENRD_LO, b);
      chk("reset_len_lo", {24'h0, b}, 32'h0);

      // Known good frame "123456789" + CRC
      set_len(16'd13);
      rd(A_LENRD_LO, b);
      chk("len_lo_readback", {24'h0, b}, 32'd13);
      rd(A_LENRD_HI, b);
      chk("len_hi_readback", {24'h0, b}, 32'd0);
      load_good_frame();
      run_frame(8);
      chk("good_uo_out", {24'h0, uo_out}, 32'h06);

      // Same frame corrupted; len is kept across clear
      wr(A_CTRL, 8'h01);
      frame[3] = 8'h30;
      run_frame(-1);

      // Random frames, about half corrupted by a single bit flip
      for (int f = 0; f < 8; f++) begin
         wr(A_CTRL, 8'h01);
         plen = $urandom_range(12, 1);
         frame.delete();
         for (int i = 0; i < plen; i++) frame.push_back(8'($urandom));
         append_crc(plen);
         if ($urandom_range(1, 0) == 1) begin
            idx = $urandom_range(plen + 3, 0);
            frame[idx] = frame[idx] ^ 8'(1 << $urandom_range(7, 0));
         end
         set_len(16'(plen + 4));
         run_frame($urandom_range(plen + 2, 0));
      end

      // Overflow: third back-to-back byte finds the hold register full
      wr(A_CTRL, 8'h01);
      set_len(16'd13);
      wr(A_DATA, 8'h11);
      wr(A_DATA, 8'h22);
      wr(A_DATA, 8'h33);
      rd(A_STATUS, b);
      chk("ovf_status_bit", {31'h0, b[3]}, 32'h1);
      idle(30);
      rd_cnt(cnt);
      chk("ovf_byte_cnt", {16'h0, cnt}, 32'd2);
      chk("ovf_uo_out", {24'h0, uo_out}, 32'h08);

      // Length error
      wr(A_CTRL, 8'h01);
      set_len(16'd3);
      exp_q.push_back(8'h0A);
      wr(A_DATA, 8'hAA);
      wait_done(5);
      rd(A_STATUS, b);
      chk("len_err_status", {24'h0, b}, 32'h12);
      rd_cnt(cnt);
      chk("len_err_byte_cnt", {16'h0, cnt}, 32'd0);
      wr(A_DATA, 8'h55);
      rd(A_STATUS, b);
      chk("len_err_then_ovf", {24'h0, b}, 32'h1A);

      // Clear two cycles after a DATA write, while shifting
      wr(A_CTRL, 8'h01);
      set_len(16'd13);
      wr(A_DATA, 8'h31);
      idle(1);
      wr(A_CTRL, 8'h01);
      rd(A_STATUS, b);
      chk("clear_status", {24'h0, b}, 32'h0);
      rd_crc(raw);
      chk("clear_crc", raw, 32'hFFFFFFFF);
      rd_cnt(cnt);
      chk("clear_byte_cnt", {16'h0, cnt}, 32'd0);
      rd(A_LENRD_LO, b);
      chk("clear_len_kept", {24'h0, b}, 32'd13);
      load_good_frame();
      run_frame(-1);

      // Asynchronous reset in the middle of a shift
      wr(A_CTRL, 8'h01);
      wr(A_DATA, 8'h31);
      idle(2);
      chk("shift_busy", {24'h0, uo_out}, 32'h01);
      #2;
      rst = 1'b1;
      rd(A_STATUS, b);
      chk("arst_status", {24'h0, b}, 32'h0);
      rd(A_LENRD_LO, b);
      chk("arst_len", {24'h0, b}, 32'h0);
      chk("arst_uo_out", {24'h0, uo_out}, 32'h0);
      idle(2);
      rst = 1'b0;
      idle(2);

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
